pmem_arbiter: RTL

- Shares the single physical-memory port between the I-cache miss path (read-only) and the D-cache miss/writeback path (read/write) of the pipelined LC-3b core.
- Grants one requester at a time and latches its command.
- Drives the shared port until it responds, then routes the response back to the granted requester.
- Sits between the two caches and pmem, below the MEM-stage control (mem_read/mem_write, is_ldi/is_sti).

---
 rtl/pmem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache fill path and the D-cache fill/writeback path.
// Define ARB_ROUND_ROBIN_EN to replace fixed D-over-I priority with an alternating pointer.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } cmd_t;

  logic [1:0] state, state_nxt;
  cmd_t       cmd_q, cmd_nxt;
  logic       i_req, d_req, grant_d, grant_i;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;  // 0: D favoured on a tie, 1: I favoured
  logic done;

  assign done    = (state != IDLE) & pmem_resp;
  assign grant_d = d_req & (~i_req | ~rr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_q <= 1'b0;
    else if (done) rr_q <= (state == SERVE_D);
  end
`else
  assign grant_d = d_req;
`endif

  assign grant_i = i_req & ~grant_d;

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt     = SERVE_D;
          cmd_nxt.rd    = d_pmem_read;
          cmd_nxt.wr    = d_pmem_write;
          cmd_nxt.addr  = d_pmem_address;
          cmd_nxt.wdata = d_pmem_wdata;
        end else if (grant_i) begin
          // I side never writes; leave the last write data in place
          state_nxt    = SERVE_I;
          cmd_nxt.rd   = 1'b1;
          cmd_nxt.wr   = 1'b0;
          cmd_nxt.addr = i_pmem_address;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_nxt  = IDLE;
          cmd_nxt.rd = 1'b0;
          cmd_nxt.wr = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        cmd_nxt.rd = 1'b0;
        cmd_nxt.wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= '0;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
    end
  end

  assign pmem_read    = cmd_q.rd;
  assign pmem_write   = cmd_q.wr;
  assign pmem_address = cmd_q.addr;
  assign pmem_wdata   = cmd_q.wdata;

  // Completion is steered by the grant state, so a resp seen in IDLE goes nowhere
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
